// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between an instruction and a data requester (data first),
// and routes in-order responses back to their issuer via a small ID FIFO.
module sram_bus_arbiter #(
   parameter int OUTST = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int PW = (OUTST > 2) ? $clog2(OUTST) : 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(OUTST);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_D = 2'd1,
      HOLD_I = 2'd2
   } state_t;

   state_t           r_state;
   logic [OUTST-1:0] r_ids;
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [PW:0]      r_count;
   logic             r_full;

   logic        w_gnt_d;
   logic        w_gnt_i;
   logic        w_push;
   logic        w_pop;
   logic        w_empty;
   logic        w_head;
   logic [PW:0] w_count_nxt;

   // Grant selection: a held state pins the grant until the memory accepts it.
   always_comb begin
      w_gnt_d = 1'b0;
      w_gnt_i = 1'b0;
      case (r_state)
         IDLE: begin
            w_gnt_d = data_req;
            w_gnt_i = ~data_req & inst_req;
         end
         HOLD_D:  w_gnt_d = 1'b1;
         HOLD_I:  w_gnt_i = 1'b1;
         default: begin
            w_gnt_d = 1'b0;
            w_gnt_i = 1'b0;
         end
      endcase
   end

   // Request path: drive the memory port straight from the granted requester.
   always_comb begin
      mem_req   = ((w_gnt_d & data_req) | (w_gnt_i & inst_req)) & ~r_full;
      mem_wr    = 1'b0;
      mem_size  = 2'b00;
      mem_addr  = 32'h0000_0000;
      mem_wstrb = 4'b0000;
      mem_wdata = 32'h0000_0000;
      if (w_gnt_d) begin
         mem_wr    = data_wr;
         mem_size  = data_size;
         mem_addr  = data_addr;
         mem_wstrb = data_wstrb;
         mem_wdata = data_wdata;
      end else if (w_gnt_i) begin
         mem_size  = 2'b10;
         mem_addr  = inst_addr;
      end else begin
         mem_wr    = 1'b0;
      end
   end

   assign data_addr_ok = mem_req & mem_addr_ok & w_gnt_d;
   assign inst_addr_ok = mem_req & mem_addr_ok & w_gnt_i;

   assign w_empty = (r_count == '0);
   assign w_push  = mem_req & mem_addr_ok;
   assign w_pop   = mem_data_ok & ~w_empty;
   assign w_head  = r_ids[r_rptr];

   assign data_data_ok = w_pop & w_head;
   assign inst_data_ok = w_pop & ~w_head;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   // Outstanding-count update for concurrent push/pop.
   always_comb begin
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // Grant FSM: park on an unaccepted request, release on acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (mem_req & ~mem_addr_ok)
                  r_state <= w_gnt_d ? HOLD_D : HOLD_I;
               else
                  r_state <= IDLE;
            end
            HOLD_D, HOLD_I: begin
               if (mem_req & mem_addr_ok)
                  r_state <= IDLE;
               else
                  r_state <= r_state;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // ID FIFO: one bit per outstanding transaction, 1 marks a data-side request.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ids   <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_push) begin
            r_ids[r_wptr] <= w_gnt_d;
            r_wptr        <= r_wptr + PTR_ONE;
         end
         if (w_pop)
            r_rptr <= r_rptr + PTR_ONE;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_FULL);
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: priority, hold, response routing, full and reset cases.
module tb_sram_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   sram_bus_arbiter #(.OUTST(2)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
      data_size = 2'b00; data_addr = 32'h0; data_wstrb = 4'h0; data_wdata = 32'h0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
      checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
         errors++; $display("FAIL reset_oks: got %b exp 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
      checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
         errors++; $display("FAIL reset_mem_fields: got %h/%h/%h exp 0", mem_addr, mem_wdata, mem_wstrb); end
      tick();
   endtask

   task automatic test_priority;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'b10; data_addr = 32'h0000_0080;
      data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
      inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
      @(negedge clk);
      checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin errors++; $display("FAIL prio_addr_ok: got d=%b i=%b exp d=1 i=0", data_addr_ok, inst_addr_ok); end
      checks++; if (mem_addr !== 32'h0000_0080) begin errors++; $display("FAIL prio_mem_addr: got %h exp 00000080", mem_addr); end
      checks++; if ({mem_wr, mem_wstrb, mem_wdata} !== {1'b1, 4'hF, 32'h1234_5678}) begin
         errors++; $display("FAIL prio_store_fields: got wr=%b strb=%h wdata=%h", mem_wr, mem_wstrb, mem_wdata); end
      tick();
      data_req = 1'b0;
      @(negedge clk);
      checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL prio_inst_next: got %b exp 1", inst_addr_ok); end
      checks++; if ({mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata} !== {32'h1C00_0000, 1'b0, 2'b10, 4'h0, 32'h0}) begin
         errors++; $display("FAIL prio_inst_fields: got addr=%h wr=%b size=%b strb=%h wdata=%h", mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata); end
      tick();
      inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0011;
      @(negedge clk);
      checks++; if ({data_data_ok, inst_data_ok, data_rdata} !== {1'b1, 1'b0, 32'h11}) begin
         errors++; $display("FAIL prio_store_ack: got d=%b i=%b rdata=%h exp d=1 i=0 rdata=11", data_data_ok, inst_data_ok, data_rdata); end
      tick();
      mem_rdata = 32'h0000_0022;
      @(negedge clk);
      checks++; if ({data_data_ok, inst_data_ok, inst_rdata} !== {1'b0, 1'b1, 32'h22}) begin
         errors++; $display("FAIL prio_inst_resp: got d=%b i=%b rdata=%h exp d=0 i=1 rdata=22", data_data_ok, inst_data_ok, inst_rdata); end
      tick();
      idle_inputs();
   endtask

   task automatic test_hold;
      inst_req = 1'b1; inst_addr = 32'h1C00_0040; mem_addr_ok = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            data_req = 1'b1; data_addr = 32'h0000_0200; data_size = 2'b10;
         end
         @(negedge clk);
         checks++; if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 32'h1C00_0040, 2'b00}) begin
            errors++; $display("FAIL hold_cycle%0d: got req=%b addr=%h i=%b d=%b exp req=1 addr=1c000040 i=0 d=0", c, mem_req, mem_addr, inst_addr_ok, data_addr_ok); end
         tick();
      end
      mem_addr_ok = 1'b1;
      @(negedge clk);
      checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL hold_accept_inst: got i=%b d=%b exp i=1 d=0", inst_addr_ok, data_addr_ok); end
      tick();
      inst_req = 1'b0;
      @(negedge clk);
      checks++; if ({data_addr_ok, mem_addr} !== {1'b1, 32'h0000_0200}) begin
         errors++; $display("FAIL hold_data_next: got d=%b addr=%h exp d=1 addr=00000200", data_addr_ok, mem_addr); end
      tick();
      idle_inputs();
      mem_data_ok = 1'b1;
      @(negedge clk);
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL hold_resp1: got i=%b d=%b exp i=1 d=0", inst_data_ok, data_data_ok); end
      tick();
      @(negedge clk);
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL hold_resp2: got i=%b d=%b exp i=0 d=1", inst_data_ok, data_data_ok); end
      tick();
      idle_inputs();
   endtask

   task automatic test_order;
      inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
      tick();
      inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0080; data_size = 2'b10;
      @(negedge clk);
      checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL order_load_issue: got %b exp 1", data_addr_ok); end
      tick();
      idle_inputs();
      mem_data_ok = 1'b1; mem_rdata = 32'h0000_00AA;
      @(negedge clk);
      checks++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {1'b1, 1'b0, 32'hAA}) begin
         errors++; $display("FAIL order_first: got i=%b d=%b rdata=%h exp i=1 d=0 rdata=aa", inst_data_ok, data_data_ok, inst_rdata); end
      tick();
      mem_rdata = 32'h0000_00BB;
      @(negedge clk);
      checks++; if ({inst_data_ok, data_data_ok, data_rdata} !== {1'b0, 1'b1, 32'hBB}) begin
         errors++; $display("FAIL order_second: got i=%b d=%b rdata=%h exp i=0 d=1 rdata=bb", inst_data_ok, data_data_ok, data_rdata); end
      tick();
      idle_inputs();
   endtask

   task automatic test_full;
      inst_req = 1'b1; inst_addr = 32'h1C00_0100; mem_addr_ok = 1'b1;
      tick(); tick();
      inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0300; data_size = 2'b10;
      @(negedge clk);
      checks++; if ({mem_req, data_addr_ok, inst_addr_ok} !== 3'b000) begin
         errors++; $display("FAIL full_block: got req=%b d=%b i=%b exp 000", mem_req, data_addr_ok, inst_addr_ok); end
      tick();
      mem_data_ok = 1'b1;
      @(negedge clk);
      checks++; if ({mem_req, inst_data_ok} !== 2'b01) begin
         errors++; $display("FAIL full_pop_same_cycle: got req=%b i_ok=%b exp req=0 i_ok=1", mem_req, inst_data_ok); end
      tick();
      mem_data_ok = 1'b0;
      @(negedge clk);
      checks++; if ({mem_req, data_addr_ok} !== 2'b11) begin
         errors++; $display("FAIL full_release: got req=%b d=%b exp 11", mem_req, data_addr_ok); end
      tick();
      idle_inputs();
      mem_data_ok = 1'b1;
      @(negedge clk);
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL full_drain1: got i=%b d=%b exp 10", inst_data_ok, data_data_ok); end
      tick();
      @(negedge clk);
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL full_drain2: got i=%b d=%b exp 01", inst_data_ok, data_data_ok); end
      tick();
      idle_inputs();
   endtask

   task automatic test_empty_response;
      mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL empty_resp: got i=%b d=%b exp 00", inst_data_ok, data_data_ok); end
      tick();
      idle_inputs();
      data_req = 1'b1; data_addr = 32'h0000_0400; mem_addr_ok = 1'b1;
      tick(); tick();
      data_req = 1'b0; mem_addr_ok = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h1C00_0200;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL empty_count_full: got req=%b exp 0", mem_req); end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid;
      mem_data_ok = 1'b1;
      tick(); tick();
      mem_data_ok = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h1C00_0300; mem_addr_ok = 1'b1;
      tick(); tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++; if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_outputs: got req=%b i=%b d=%b exp 000", mem_req, inst_addr_ok, data_addr_ok); end
      mem_data_ok = 1'b1;
      @(negedge clk);
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_mid_fifo_empty: got i=%b d=%b exp 00", inst_data_ok, data_data_ok); end
      tick();
      mem_data_ok = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h1C00_0400; mem_addr_ok = 1'b0;
      tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      data_req = 1'b1; data_addr = 32'h0000_0500; inst_req = 1'b1; inst_addr = 32'h1C00_0400; mem_addr_ok = 1'b1;
      @(negedge clk);
      checks++; if ({data_addr_ok, inst_addr_ok, mem_addr} !== {2'b10, 32'h0000_0500}) begin
         errors++; $display("FAIL rst_mid_fsm_idle: got d=%b i=%b addr=%h exp d=1 i=0 addr=00000500", data_addr_ok, inst_addr_ok, mem_addr); end
      tick();
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_priority();
      test_hold();
      test_order();
      test_full();
      test_empty_response();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
